// File: rtl/d_bch_encoder_param_top.sv
// Parallel-LFSR systematic BCH encoder with ready/valid message and parity buses.
// Define D_BCH_ENC_CODEWORD_OUT_EN to pass message blocks through on the parity bus.
module d_bch_encoder_param_top #(
    parameter int unsigned            P_LVL        = 8,
    parameter int unsigned            PRT_LENGTH   = 112,
    parameter int unsigned            MAX_M_BLOCKS = 1024,
    parameter logic [PRT_LENGTH-1:0]  GEN_POLY     = 112'h8ED745A31C9B60F2D5E13B7A4C29,
    parameter int unsigned            CNT_W        = 11
) (
    input  logic             i_clk,
    input  logic             i_RESET,
    input  logic             i_exe_encoding,
    input  logic [CNT_W-1:0] i_num_m_blocks,
    input  logic             i_message_valid,
    input  logic [P_LVL-1:0] i_message,
    output logic             o_message_ready,
    output logic             o_encoding_start,
    output logic             o_last_m_block_rcvd,
    output logic             o_encoding_cmplt,
    input  logic             i_parity_ready,
    output logic             o_parity_valid,
    output logic [P_LVL-1:0] o_parity_out,
    output logic             o_parity_out_start,
    output logic             o_parity_out_cmplt,
    output logic             o_busy
);

    localparam int unsigned      N_PAR_BLK = PRT_LENGTH / P_LVL;
    localparam logic [CNT_W-1:0] MAX_N     = CNT_W'(MAX_M_BLOCKS);
    localparam logic [CNT_W-1:0] LAST_PAR  = CNT_W'(N_PAR_BLK - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'b001,
        S_ENCODE  = 3'b010,
        S_PAR_OUT = 3'b100
    } state_e;

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        nblk_q;
    logic [PRT_LENGTH-1:0]   par_q;
    logic [PRT_LENGTH-1:0]   par_d;
    logic                    enc_start_q;
    logic                    enc_cmplt_q;

    logic                    st_enc;
    logic                    st_par;
    logic                    msg_rdy;
    logic                    msg_hs;
    logic                    last_msg;
    logic                    par_hs;
    logic                    last_par;
    logic [CNT_W-1:0]        n_sel;

    assign st_enc = state_q[1];
    assign st_par = state_q[2];

`ifdef D_BCH_ENC_CODEWORD_OUT_EN
    assign msg_rdy = st_enc & i_parity_ready;
`else
    assign msg_rdy = st_enc;
`endif

    assign msg_hs   = st_enc & i_message_valid & msg_rdy;
    assign last_msg = msg_hs & (cnt_q == nblk_q - 1'b1);
    assign par_hs   = st_par & i_parity_ready;
    assign last_par = par_hs & (cnt_q == LAST_PAR);

    // Zero and oversized lengths both mean a maximum-length frame.
    assign n_sel = ((i_num_m_blocks == '0) || (i_num_m_blocks > MAX_N))
                   ? MAX_N : i_num_m_blocks;

    always_comb begin : lfsr_step
        logic fb;
        fb    = 1'b0;
        par_d = par_q;
        for (int b = 0; b < P_LVL; b++) begin
            fb    = i_message[P_LVL-1-b] ^ par_d[PRT_LENGTH-1];
            par_d = {par_d[PRT_LENGTH-2:0], 1'b0} ^ (fb ? GEN_POLY : '0);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_RESET) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            nblk_q      <= '0;
            par_q       <= '0;
            enc_start_q <= 1'b0;
            enc_cmplt_q <= 1'b0;
        end else begin
            enc_start_q <= 1'b0;
            enc_cmplt_q <= 1'b0;
            unique case (1'b1)
                state_q[0]: begin
                    if (i_exe_encoding) begin
                        state_q     <= S_ENCODE;
                        nblk_q      <= n_sel;
                        cnt_q       <= '0;
                        par_q       <= '0;
                        enc_start_q <= 1'b1;
                    end
                end
                state_q[1]: begin
                    if (msg_hs) begin
                        par_q <= par_d;
                        if (last_msg) begin
                            state_q     <= S_PAR_OUT;
                            cnt_q       <= '0;
                            enc_cmplt_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                state_q[2]: begin
                    if (par_hs) begin
                        par_q <= par_q << P_LVL;
                        if (last_par) begin
                            state_q <= S_IDLE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign o_message_ready     = msg_rdy;
    assign o_encoding_start    = enc_start_q;
    assign o_encoding_cmplt    = enc_cmplt_q;
    assign o_last_m_block_rcvd = last_msg;
    assign o_parity_out_start  = st_par & (cnt_q == '0);
    assign o_parity_out_cmplt  = last_par;
    assign o_busy              = (state_q != S_IDLE);

`ifdef D_BCH_ENC_CODEWORD_OUT_EN
    assign o_parity_valid = st_par | (st_enc & i_message_valid);
    assign o_parity_out   = st_par ? par_q[PRT_LENGTH-1 -: P_LVL]
                          : (st_enc ? i_message : '0);
`else
    assign o_parity_valid = st_par;
    assign o_parity_out   = st_par ? par_q[PRT_LENGTH-1 -: P_LVL] : '0;
`endif

endmodule

// File: tb/tb_d_bch_encoder_param_top.sv
// Directed bench for d_bch_encoder_param_top: small hand-checked config plus
// default config against a polynomial long-division reference.
module tb_d_bch_encoder_param_top;

    localparam logic [111:0] GP = 112'h8ED745A31C9B60F2D5E13B7A4C29;
`ifdef D_BCH_ENC_CODEWORD_OUT_EN
    localparam bit CW = 1'b1;
`else
    localparam bit CW = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        exe = 1'b0;
    logic [10:0] num = '0;
    logic        mvalid = 1'b0;
    logic [7:0]  mdata = '0;
    logic        pready = 1'b0;
    logic        mready, estart, lastr, ecmplt;
    logic        pvalid, pstart, pcmplt, busy;
    logic [7:0]  pout;

    logic        s_exe = 1'b0;
    logic [10:0] s_num = '0;
    logic        s_mvalid = 1'b0;
    logic [7:0]  s_mdata = '0;
    logic        s_pready = 1'b0;
    logic        s_mready, s_estart, s_lastr, s_ecmplt;
    logic        s_pvalid, s_pstart, s_pcmplt, s_busy;
    logic [7:0]  s_pout;

    int n_chk = 0;
    int n_pass = 0;
    logic [7:0] msgs [0:7];

    d_bch_encoder_param_top #(
        .P_LVL(8), .PRT_LENGTH(112), .MAX_M_BLOCKS(1024),
        .GEN_POLY(GP), .CNT_W(11)
    ) dut (
        .i_clk(clk), .i_RESET(rst),
        .i_exe_encoding(exe), .i_num_m_blocks(num),
        .i_message_valid(mvalid), .i_message(mdata),
        .o_message_ready(mready), .o_encoding_start(estart),
        .o_last_m_block_rcvd(lastr), .o_encoding_cmplt(ecmplt),
        .i_parity_ready(pready), .o_parity_valid(pvalid),
        .o_parity_out(pout), .o_parity_out_start(pstart),
        .o_parity_out_cmplt(pcmplt), .o_busy(busy)
    );

    d_bch_encoder_param_top #(
        .P_LVL(8), .PRT_LENGTH(8), .MAX_M_BLOCKS(1024),
        .GEN_POLY(8'h07), .CNT_W(11)
    ) dut_s (
        .i_clk(clk), .i_RESET(rst),
        .i_exe_encoding(s_exe), .i_num_m_blocks(s_num),
        .i_message_valid(s_mvalid), .i_message(s_mdata),
        .o_message_ready(s_mready), .o_encoding_start(s_estart),
        .o_last_m_block_rcvd(s_lastr), .o_encoding_cmplt(s_ecmplt),
        .i_parity_ready(s_pready), .o_parity_valid(s_pvalid),
        .o_parity_out(s_pout), .o_parity_out_start(s_pstart),
        .o_parity_out_cmplt(s_pcmplt), .o_busy(s_busy)
    );

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Remainder of M(x)*x^112 mod g(x) by explicit long division.
    function automatic logic [111:0] golden(input int n);
        logic [175:0] d;
        d = '0;
        for (int i = 0; i < n; i++) d[8*n+111-8*i -: 8] = msgs[i];
        for (int p = 8*n+111; p >= 112; p--)
            if (d[p]) d[p -: 113] = d[p -: 113] ^ {1'b1, GP};
        return d[111:0];
    endfunction

    task automatic run_frame(input string tag, input int n,
                             input bit gap, input bit bp);
        logic [111:0] par;
        logic [7:0]   exp_b [0:21];
        logic [7:0]   held;
        bit           stalled;
        int nblk, off, sent, got, cyc;
        int n_last, last_at, n_es, n_ec, n_pc, pc_at, bad_ps, bad_enc;
        par  = golden(n);
        off  = CW ? n : 0;
        nblk = off + 14;
        for (int k = 0; k < nblk; k++)
            exp_b[k] = (k < off) ? msgs[k] : par[111-8*(k-off) -: 8];
        sent = 0; got = 0; cyc = 0; stalled = 1'b0; held = '0;
        n_last = 0; last_at = -1; n_es = 0; n_ec = 0;
        n_pc = 0; pc_at = -1; bad_ps = 0; bad_enc = 0;
        @(negedge clk);
        exe = 1'b1; num = 11'(n);
        @(negedge clk);
        exe = 1'b0;
        while (got < nblk && cyc < 500) begin
            mvalid = (sent < n) && (!gap || (cyc % 3 == 0));
            mdata  = (sent < n) ? msgs[sent] : 8'h00;
            pready = bp ? (cyc % 2 == 1) : 1'b1;
            #1;
            if (estart) n_es++;
            if (ecmplt) n_ec++;
            if (lastr) begin n_last++; last_at = sent; end
            if (pcmplt) begin n_pc++; pc_at = got; end
            if (pstart !== (pvalid && got == off)) bad_ps++;
            if (sent < n) begin
                if (mready !== (CW ? pready : 1'b1)) bad_enc++;
                if (pvalid !== (CW ? mvalid : 1'b0)) bad_enc++;
            end
            if (pvalid && stalled)
                check({tag, "_hold"}, pout, held);
            stalled = pvalid && !pready;
            held    = pout;
            if (pvalid && pready) begin
                check($sformatf("%s_blk%0d", tag, got), pout, exp_b[got]);
                got++;
            end
            if (mvalid && mready) sent++;
            cyc++;
            @(negedge clk);
        end
        mvalid = 1'b0; pready = 1'b0;
        #1;
        check({tag, "_done"}, got, nblk);
        check({tag, "_busy_after"}, busy, 1'b0);
        check({tag, "_pvalid_after"}, pvalid, 1'b0);
        check({tag, "_n_last"}, n_last, 1);
        check({tag, "_last_at"}, last_at, n - 1);
        check({tag, "_n_estart"}, n_es, 1);
        check({tag, "_n_ecmplt"}, n_ec, 1);
        check({tag, "_n_pcmplt"}, n_pc, 1);
        check({tag, "_pcmplt_at"}, pc_at, nblk - 1);
        check({tag, "_pstart"}, bad_ps, 0);
        check({tag, "_enc_bus"}, bad_enc, 0);
    endtask

    task automatic s_frame(input string tag, input logic [7:0] m,
                           input logic [7:0] p);
        int nb, got, sent, cyc;
        nb = CW ? 2 : 1;
        got = 0; sent = 0; cyc = 0;
        @(negedge clk);
        s_exe = 1'b1; s_num = 11'd1;
        @(negedge clk);
        s_exe = 1'b0;
        while (got < nb && cyc < 20) begin
            s_mvalid = (sent == 0);
            s_mdata  = m;
            s_pready = 1'b1;
            #1;
            if (s_pvalid) begin
                check($sformatf("%s_blk%0d", tag, got), s_pout,
                      (got < nb - 1) ? m : p);
                check($sformatf("%s_cmplt%0d", tag, got), s_pcmplt,
                      got == nb - 1);
                got++;
            end
            if (s_mvalid && s_mready) sent++;
            cyc++;
            @(negedge clk);
        end
        s_mvalid = 1'b0; s_pready = 1'b0;
        #1;
        check({tag, "_done"}, got, nb);
        check({tag, "_busy_after"}, s_busy, 1'b0);
    endtask

    task automatic reset_mid();
        @(negedge clk);
        exe = 1'b1; num = 11'd4;
        @(negedge clk);
        exe = 1'b0; mvalid = 1'b1; mdata = msgs[0]; pready = 1'b1;
        @(negedge clk);
        mdata = msgs[1];
        @(negedge clk);
        mvalid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_pvalid", pvalid, 1'b0);
        check("rst_mid_pout", pout, 8'h00);
        check("rst_mid_mready", mready, 1'b0);
        pready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_mready", mready, 1'b0);
        check("rst_pvalid", pvalid, 1'b0);
        check("rst_pout", pout, 8'h00);
        check("rst_flags", {estart, lastr, ecmplt, pstart, pcmplt}, 5'b0);
        check("rst_s_busy", s_busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        s_frame("s01", 8'h01, 8'h07);
        s_frame("s00", 8'h00, 8'h00);
        s_frame("s80", 8'h80, 8'h89);

        msgs[0] = 8'hA5; msgs[1] = 8'h3C; msgs[2] = 8'hF0; msgs[3] = 8'h19;
        run_frame("base", 4, 1'b0, 1'b0);
        run_frame("bp", 4, 1'b0, 1'b1);
        run_frame("gap", 4, 1'b1, 1'b0);

        reset_mid();
        msgs[0] = 8'h5E; msgs[1] = 8'h00; msgs[2] = 8'hFF; msgs[3] = 8'h81;
        run_frame("post_rst", 4, 1'b0, 1'b0);

        msgs[0] = 8'hC3; msgs[1] = 8'h7E;
        run_frame("n2", 2, 1'b0, 1'b0);
        run_frame("n2_bp", 2, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
